io_bridge: RTL and testbench

Address-decoding bridge between the `cpu` bus master and the `mem_controller` RAM slave. It claims a small memory-mapped I/O window for the 16 external LEDs, the seven-segment display word and the matrix-keypad keys, and forwards every other access to the memory controller over the same hello/ack handshake. It also runs a bus watchdog so that a slave which never answers cannot hang the CPU.

---
 rtl/io_bridge.sv | 173 +++++++++++++++++
 tb/tb_io_bridge.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_bridge
// Purpose  : CPU bus address decoder. Serves a small I/O window (LEDs,
//            seven-segment word, sticky keypad) locally and forwards every
//            other access to the memory controller over the same hello/ack
//            handshake, guarded by a bus watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module io_bridge #(
  parameter int                WORD_W  = 16,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] IO_LED  = 8'hF0,
  parameter logic [ADDR_W-1:0] IO_SEG  = 8'hF1,
  parameter logic [ADDR_W-1:0] IO_KEY  = 8'hF2,
  parameter int                TIMEOUT = 15
) (
  input  logic              ib_clk_i,
  input  logic              ib_rst_i,
  input  logic              cpu_hello_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_ack_o,
  output logic              mem_hello_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_data_o,
  input  logic [WORD_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  input  logic [15:0]       keys_i,
  output logic [15:0]       led_o,
  output logic [WORD_W-1:0] seg_o,
  output logic              err_o
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_io      = 2'd1;
  localparam logic [1:0] c_mem     = 2'd2;
  localparam logic [1:0] c_release = 2'd3;

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  logic [1:0]        r_state;
  logic              r_req_we;
  logic [ADDR_W-1:0] r_req_addr;
  logic [WORD_W-1:0] r_req_data;
  logic [7:0]        r_count;
  logic [15:0]       r_keys_q;
  logic [15:0]       r_sticky;
  logic [15:0]       r_led;
  logic [WORD_W-1:0] r_seg;
  logic [WORD_W-1:0] r_cpu_data;
  logic              r_cpu_ack;
  logic              r_mem_hello;
  logic              r_err;

  logic              w_is_io;
  logic [15:0]       w_rise;
  logic [15:0]       w_key_clr;
  logic [WORD_W-1:0] w_io_rdata;

  assign w_is_io = (cpu_addr_i == IO_LED) || (cpu_addr_i == IO_SEG) ||
                   (cpu_addr_i == IO_KEY);

  assign w_rise = keys_i & ~r_keys_q;

  // A keypad read clears exactly the bits it returns, i.e. the current sticky value.
  assign w_key_clr = (r_state == c_io && !r_req_we && r_req_addr == IO_KEY) ?
                     r_sticky : 16'h0000;

  // Read data for the I/O window, zero-extended to the bus width.
  always_comb begin
    w_io_rdata = '0;
    if (r_req_addr == IO_LED) begin
      w_io_rdata[15:0] = r_led;
    end else if (r_req_addr == IO_SEG) begin
      w_io_rdata = r_seg;
    end else begin
      w_io_rdata[15:0] = r_sticky;
    end
  end

  // Key history and sticky rising-edge flags; a new edge beats a same-cycle clear.
  always_ff @(posedge ib_clk_i or posedge ib_rst_i) begin
    if (ib_rst_i) begin
      r_keys_q <= 16'h0000;
      r_sticky <= 16'h0000;
    end else begin
      r_keys_q <= keys_i;
      r_sticky <= (r_sticky & ~w_key_clr) | w_rise;
    end
  end

  // Request FSM: decode, local I/O access, forwarded access with watchdog, release.
  always_ff @(posedge ib_clk_i or posedge ib_rst_i) begin
    if (ib_rst_i) begin
      r_state     <= c_idle;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_count     <= 8'd0;
      r_led       <= 16'h0000;
      r_seg       <= '0;
      r_cpu_data  <= '0;
      r_cpu_ack   <= 1'b0;
      r_mem_hello <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        c_idle: begin
          if (cpu_hello_i) begin
            r_req_we   <= cpu_we_i;
            r_req_addr <= cpu_addr_i;
            r_req_data <= cpu_data_i;
            r_count    <= 8'd0;
            r_state    <= w_is_io ? c_io : c_mem;
          end
        end
        c_io: begin
          r_cpu_ack <= 1'b1;
          if (r_req_we) begin
            if (r_req_addr == IO_LED) begin
              r_led <= r_req_data[15:0];
            end else if (r_req_addr == IO_SEG) begin
              r_seg <= r_req_data;
            end
          end else begin
            r_cpu_data <= w_io_rdata;
          end
          r_state <= c_release;
        end
        c_mem: begin
          // The first MEM cycle raises hello; an ack only counts once hello is out.
          if (r_mem_hello && mem_ack_i) begin
            r_cpu_data  <= mem_data_i;
            r_cpu_ack   <= 1'b1;
            r_mem_hello <= 1'b0;
            r_state     <= c_release;
          end else if (r_count == c_timeout) begin
            r_cpu_data  <= '1;
            r_cpu_ack   <= 1'b1;
            r_err       <= 1'b1;
            r_mem_hello <= 1'b0;
            r_state     <= c_release;
          end else begin
            r_count     <= r_count + 8'd1;
            r_mem_hello <= 1'b1;
          end
        end
        default: begin
          if (!cpu_hello_i) begin
            r_state <= c_idle;
          end
        end
      endcase
    end
  end

  assign cpu_data_o  = r_cpu_data;
  assign cpu_ack_o   = r_cpu_ack;
  assign mem_hello_o = r_mem_hello;
  assign mem_we_o    = r_req_we;
  assign mem_addr_o  = r_req_addr;
  assign mem_data_o  = r_req_data;
  assign led_o       = r_led;
  assign seg_o       = r_seg;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bridge
// Purpose  : Self-checking bench for io_bridge with a latency-programmable
//            memory slave and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bridge;

  localparam int TIMEOUT = 15;

  logic        ib_clk_i = 1'b0;
  logic        ib_rst_i;
  logic        cpu_hello_i;
  logic        cpu_we_i;
  logic [7:0]  cpu_addr_i;
  logic [15:0] cpu_data_i;
  logic [15:0] cpu_data_o;
  logic        cpu_ack_o;
  logic        mem_hello_o;
  logic        mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_data_o;
  logic [15:0] mem_data_i;
  logic        mem_ack_i;
  logic [15:0] keys_i;
  logic [15:0] led_o;
  logic [15:0] seg_o;
  logic        err_o;

  int n_chk = 0;
  int n_err = 0;

  // slave configuration: ack after mem_lat cycles of hello (0 = never)
  int   mem_lat = 1;
  logic late_ack = 1'b0;
  logic [15:0] slave_mem [256];

  // reference model state
  logic [15:0] ref_mem [256];
  logic [15:0] m_led, m_seg, m_sticky;
  logic        m_err;

  io_bridge #(
    .WORD_W (16),
    .ADDR_W (8),
    .IO_LED (8'hF0),
    .IO_SEG (8'hF1),
    .IO_KEY (8'hF2),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .ib_clk_i   (ib_clk_i),
    .ib_rst_i   (ib_rst_i),
    .cpu_hello_i(cpu_hello_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .cpu_ack_o  (cpu_ack_o),
    .mem_hello_o(mem_hello_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i),
    .keys_i     (keys_i),
    .led_o      (led_o),
    .seg_o      (seg_o),
    .err_o      (err_o)
  );

  always #5 ib_clk_i = ~ib_clk_i;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Memory slave: counts cycles of hello and acks on the programmed cycle.
  initial begin : mem_model
    int hcnt;
    hcnt = 0;
    for (int i = 0; i < 256; i++) slave_mem[i] = 16'(i * 40503 + 7);
    mem_ack_i  = 1'b0;
    mem_data_i = 16'h0000;
    forever begin
      @(posedge ib_clk_i);
      #2;
      if (mem_hello_o) begin
        hcnt++;
        if (mem_lat > 0 && hcnt == mem_lat) begin
          mem_ack_i  = 1'b1;
          mem_data_i = slave_mem[mem_addr_o];
          if (mem_we_o) slave_mem[mem_addr_o] = mem_data_o;
        end else begin
          mem_ack_i = late_ack;
        end
      end else begin
        hcnt      = 0;
        mem_ack_i = late_ack;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ib_clk_i);
    #1;
  endtask

  task automatic set_keys(input logic [15:0] v);
    m_sticky = m_sticky | (v & ~keys_i);
    keys_i   = v;
  endtask

  // One CPU transaction; checks completion timing, handshake shape and hold behaviour.
  task automatic access(input bit we, input logic [7:0] a, input logic [15:0] d,
                        input int lat, input int hold, input bit late,
                        output logic [15:0] rdata);
    bit io, got, saw_mh;
    int k, exp_k;
    io    = (a == 8'hF0) || (a == 8'hF1) || (a == 8'hF2);
    exp_k = io ? 1 : ((lat >= 1 && lat <= TIMEOUT) ? lat + 1 : TIMEOUT + 1);
    mem_lat     = lat;
    cpu_hello_i = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = a;
    cpu_data_i  = d;
    got = 0; saw_mh = 0; k = -1;
    while (!got && k < TIMEOUT + 8) begin
      tick();
      k++;
      if (mem_hello_o && !saw_mh) begin
        saw_mh = 1;
        chk("mem_addr", mem_addr_o, a);
        chk("mem_we", mem_we_o, we);
        if (we) chk("mem_wdata", mem_data_o, d);
      end
      if (cpu_ack_o) got = 1;
    end
    chk("ack_latency", got ? k : -1, exp_k);
    chk("mem_hello_used", saw_mh, !io);
    rdata = cpu_data_o;
    tick();
    chk("ack_one_cycle", cpu_ack_o, 1'b0);
    for (int h = 0; h < hold; h++) begin
      late_ack = (h == 0) ? late : 1'b0;
      tick();
      chk("hold_quiet", {cpu_ack_o, mem_hello_o}, 2'b00);
    end
    late_ack = 1'b0;
    chk("data_held", cpu_data_o, rdata);
    cpu_hello_i = 1'b0;
    tick();
  endtask

  initial begin : main
    logic [15:0] rd, exp;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 40503 + 7);
    m_led = 0; m_seg = 0; m_sticky = 0; m_err = 0;
    ib_rst_i = 1'b1; cpu_hello_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
    keys_i = 0;
    tick(); tick();
    chk("rst_outputs", {cpu_ack_o, mem_hello_o, mem_we_o, err_o}, 4'b0000);
    chk("rst_data", {cpu_data_o, mem_data_o}, 32'h0);
    chk("rst_regs", {led_o, seg_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 8'h00);
    ib_rst_i = 1'b0;
    tick();

    // LED write and read-back
    access(1, 8'hF0, 16'hA5C3, 0, 0, 0, rd);
    m_led = 16'hA5C3;
    chk("led_write", led_o, 16'hA5C3);
    access(0, 8'hF0, 16'h0000, 0, 0, 0, rd);
    chk("led_read", rd, 16'hA5C3);

    // memory write with a held hello
    access(1, 8'h10, 16'h1234, 3, 5, 0, rd);
    chk("mem_wr_resp", rd, ref_mem[8'h10]);
    ref_mem[8'h10] = 16'h1234;

    // memory read of a known word
    access(1, 8'h20, 16'hBEEF, 1, 0, 0, rd);
    chk("mem_wr2_resp", rd, ref_mem[8'h20]);
    ref_mem[8'h20] = 16'hBEEF;
    access(0, 8'h20, 16'h0000, 2, 3, 0, rd);
    chk("mem_read_beef", rd, 16'hBEEF);
    access(0, 8'h10, 16'h0000, 1, 0, 0, rd);
    chk("mem_read_1234", rd, 16'h1234);

    // watchdog timeout with a late ack in release
    access(0, 8'h40, 16'h0000, 0, 3, 1, rd);
    m_err = 1;
    chk("timeout_data", rd, 16'hFFFF);
    chk("timeout_err", err_o, 1'b1);
    access(1, 8'hF1, 16'h5A5A, 0, 0, 0, rd);
    m_seg = 16'h5A5A;
    chk("seg_after_timeout", seg_o, 16'h5A5A);
    chk("err_sticky", err_o, 1'b1);

    // sticky keys
    set_keys(16'h0011); tick(); set_keys(16'h0000); tick();
    access(0, 8'hF2, 16'h0000, 0, 0, 0, rd);
    chk("keys_first", rd, 16'h0011);
    chk("keys_first_model", rd, m_sticky);
    m_sticky = 0;
    // read again with key 3 rising in the clear cycle
    exp = m_sticky;
    m_sticky = 0;
    cpu_hello_i = 1; cpu_we_i = 0; cpu_addr_i = 8'hF2;
    tick();
    set_keys(16'h0004);
    tick();
    chk("keys_clr_ack", cpu_ack_o, 1'b1);
    chk("keys_second", cpu_data_o, exp);
    tick();
    cpu_hello_i = 0;
    tick();
    set_keys(16'h0000);
    tick();
    access(0, 8'hF2, 16'h0000, 0, 0, 0, rd);
    chk("keys_set_wins", rd, 16'h0004);
    m_sticky = 0;

    // asynchronous reset in the middle of a memory access
    mem_lat = 0;
    cpu_hello_i = 1; cpu_we_i = 1; cpu_addr_i = 8'h33; cpu_data_i = 16'h7777;
    tick(); tick(); tick();
    chk("mid_mem_hello", mem_hello_o, 1'b1);
    #2;
    ib_rst_i = 1'b1;
    #1;
    chk("arst_hello", {mem_hello_o, cpu_ack_o, err_o}, 3'b000);
    chk("arst_regs", {led_o, seg_o}, 32'h0);
    chk("arst_data", cpu_data_o, 16'h0000);
    cpu_hello_i = 0;
    tick(); tick();
    ib_rst_i = 1'b0;
    m_led = 0; m_seg = 0; m_sticky = 0; m_err = 0;
    tick();
    access(1, 8'h33, 16'h7777, 2, 0, 0, rd);
    chk("post_rst_wr", rd, ref_mem[8'h33]);
    ref_mem[8'h33] = 16'h7777;
    access(0, 8'h33, 16'h0000, 1, 0, 0, rd);
    chk("post_rst_rd", rd, 16'h7777);
    chk("post_rst_err", err_o, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int op, lat;
      logic [7:0] a;
      logic [15:0] d;
      bit we;
      op  = $urandom_range(0, 6);
      d   = 16'($urandom);
      a   = 8'($urandom_range(0, 239));
      lat = $urandom_range(1, 6);
      we  = 1'($urandom);
      case (op)
        0: begin
          access(1, 8'hF0, d, 0, 0, 0, rd);
          m_led = d;
          chk("rnd_led", led_o, m_led);
        end
        1: begin
          access(1, 8'hF1, d, 0, 0, 0, rd);
          m_seg = d;
          chk("rnd_seg", seg_o, m_seg);
        end
        2: begin
          access(0, 8'hF0, d, 0, 1, 0, rd);
          chk("rnd_led_rd", rd, m_led);
        end
        3: begin
          access(0, 8'hF1, d, 0, 0, 0, rd);
          chk("rnd_seg_rd", rd, m_seg);
        end
        4: begin
          set_keys(16'($urandom)); tick(); set_keys(16'h0000); tick();
        end
        5: begin
          exp = m_sticky;
          access(0, 8'hF2, d, 0, 0, 0, rd);
          m_sticky = 0;
          chk("rnd_keys", rd, exp);
        end
        default: begin
          exp = ref_mem[a];
          access(we, a, d, lat, $urandom_range(0, 2), 0, rd);
          if (we) ref_mem[a] = d;
          chk("rnd_mem", rd, exp);
        end
      endcase
      chk("rnd_err", err_o, m_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
